// File: rtl/procedural_sched.sv
// Round-robin scheduler sharing one two-stage procedural mix datapath between two requesters.
// Optional grant statistics are compiled in with the PROC_SCHED_STATS_EN macro.
module procedural_sched #(
    parameter int unsigned WIDTH = 16
`ifdef PROC_SCHED_STATS_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic             req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic             req1_sel,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out1,
    output logic [WIDTH-1:0] rsp_out2,
    output logic             busy
`ifdef PROC_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] grant0_cnt,
    output logic [CNT_W-1:0] grant1_cnt
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_T1   = 2'd1;
    localparam logic [1:0] S_T2   = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_last_grant;
    logic             r_id;
    logic             r_sel;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_t1;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_out1;
    logic [WIDTH-1:0] r_rsp_out2;

    logic             w_idle;
    logic             w_both;
    logic             w_grant_id;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_t1;
    logic [WIDTH-1:0] w_temp2;
    logic [WIDTH-1:0] w_out1;
    logic [WIDTH-1:0] w_out2;

    // Arbitration: a tie goes to the requester that did not win last time.
    always_comb begin
        w_idle     = (r_state == S_IDLE) && !rst;
        w_both     = req0_valid && req1_valid;
        w_grant_id = w_both ? ~r_last_grant : req1_valid;
        req0_ready = w_idle && req0_valid && !w_grant_id;
        req1_ready = w_idle && req1_valid && w_grant_id;
        w_accept   = req0_ready || req1_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_T1;
                end
            end
            S_T1:   w_state_nxt = S_T2;
            S_T2:   w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Mix datapath; every result wraps modulo 2^WIDTH.
    always_comb begin
        w_sum   = r_a + r_b;
        w_t1    = (w_sum << 3) + (w_sum << 1);
        w_temp2 = r_sel ? (r_t1 ^ (r_a >> 2)) : (r_t1 | (r_b << 3));
        w_out1  = r_sel ? (w_temp2 & r_b) : (w_temp2 + r_a);
        w_out2  = r_t1 - w_temp2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_sel        <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_t1         <= '0;
        end else begin
            if (w_accept) begin
                r_last_grant <= w_grant_id;
                r_id         <= w_grant_id;
                r_sel        <= w_grant_id ? req1_sel : req0_sel;
                r_a          <= w_grant_id ? req1_in1 : req0_in1;
                r_b          <= w_grant_id ? req1_in2 : req0_in2;
            end
            if (r_state == S_T1) begin
                r_t1 <= w_t1;
            end
        end
    end

    // Response registers hold steady in RESP until the consumer takes them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_out1  <= '0;
            r_rsp_out2  <= '0;
        end else if (r_state == S_T2) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_out1  <= w_out1;
            r_rsp_out2  <= w_out2;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_out1  = r_rsp_out1;
    assign rsp_out2  = r_rsp_out2;
    assign busy      = (r_state != S_IDLE);

`ifdef PROC_SCHED_STATS_EN
    logic [CNT_W-1:0] r_grant0_cnt;
    logic [CNT_W-1:0] r_grant1_cnt;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant0_cnt <= '0;
            r_grant1_cnt <= '0;
        end else if (w_accept) begin
            if (!w_grant_id && (r_grant0_cnt != '1)) begin
                r_grant0_cnt <= r_grant0_cnt + CNT_W'(1);
            end
            if (w_grant_id && (r_grant1_cnt != '1)) begin
                r_grant1_cnt <= r_grant1_cnt + CNT_W'(1);
            end
        end
    end

    assign grant0_cnt = r_grant0_cnt;
    assign grant1_cnt = r_grant1_cnt;
`endif

endmodule

// File: tb/tb_procedural_sched.sv
// Directed bench for procedural_sched: single ops, wrap, contention, backpressure, mid-op reset.
// Grant counters are exercised when PROC_SCHED_STATS_EN is defined.
module tb_procedural_sched;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req0_ready, req0_sel;
    logic [WIDTH-1:0] req0_in1, req0_in2;
    logic             req1_valid, req1_ready, req1_sel;
    logic [WIDTH-1:0] req1_in1, req1_in2;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_out1, rsp_out2;
`ifdef PROC_SCHED_STATS_EN
    logic [7:0]       grant0_cnt, grant1_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    procedural_sched #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_in1   (req0_in1),
        .req0_in2   (req0_in2),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_in1   (req1_in1),
        .req1_in2   (req1_in2),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out1   (rsp_out1),
        .rsp_out2   (rsp_out2),
        .busy       (busy)
`ifdef PROC_SCHED_STATS_EN
        ,
        .grant0_cnt (grant0_cnt),
        .grant1_cnt (grant1_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic id, input logic v, input logic [15:0] a,
                           input logic [15:0] b, input logic s);
        if (!id) begin
            req0_valid = v; req0_in1 = a; req0_in2 = b; req0_sel = s;
        end else begin
            req1_valid = v; req1_in1 = a; req1_in2 = b; req1_sel = s;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_busy"},  32'(busy),      32'h0);
        check({tag, "_id"},    32'(rsp_id),    32'h0);
        check({tag, "_out1"},  32'(rsp_out1),  32'h0);
        check({tag, "_out2"},  32'(rsp_out2),  32'h0);
        check({tag, "_rdy0"},  32'(req0_ready), 32'h0);
        check({tag, "_rdy1"},  32'(req1_ready), 32'h0);
    endtask

    // Counts falling edges until rsp_valid, then checks latency and payload.
    task automatic wait_rsp(input string tag, input logic eid, input logic [15:0] e1,
                            input logic [15:0] e2, input int elat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 16);
        check({tag, "_lat"},  32'(n),        32'(elat));
        check({tag, "_id"},   32'(rsp_id),   32'(eid));
        check({tag, "_out1"}, 32'(rsp_out1), 32'(e1));
        check({tag, "_out2"}, 32'(rsp_out2), 32'(e2));
    endtask

    // Called at a falling edge; issues one op and waits for its response.
    task automatic run_op(input string tag, input logic id, input logic [15:0] a,
                          input logic [15:0] b, input logic s,
                          input logic [15:0] e1, input logic [15:0] e2);
        int   n;
        logic rdy;
        set_req(id, 1'b1, a, b, s);
        #1;
        n   = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 12) begin
            @(negedge clk);
            #1;
            n++;
            rdy = id ? req1_ready : req0_ready;
        end
        check({tag, "_ready"}, 32'(rdy), 32'h1);
        @(negedge clk);
        set_req(id, 1'b0, a, b, s);
        check({tag, "_busy"}, 32'(busy), 32'h1);
        wait_rsp(tag, id, e1, e2, 2);
    endtask

    initial begin
        logic seen;
        rst       = 1'b1;
        rsp_ready = 1'b0;
        set_req(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // T1 single op, then idle one cycle after the handshake
        rsp_ready = 1'b1;
        run_op("t1", 1'b0, 16'd4, 16'd3, 1'b1, 16'h0003, 16'hFFFF);
        @(negedge clk);
        check("t1_post_valid", 32'(rsp_valid), 32'h0);
        check("t1_post_busy",  32'(busy),      32'h0);

        // T2 wrap-around
        run_op("t2", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0007, 16'hFFF8);
        @(negedge clk);

        // T3 contention from reset, both held valid
        rst = 1'b1;
        set_req(1'b0, 1'b1, 16'd16, 16'd0, 1'b1);
        set_req(1'b1, 1'b1, 16'd4,  16'd3, 1'b1);
        #1;
        check("t3_rst_rdy0", 32'(req0_ready), 32'h0);
        check("t3_rst_rdy1", 32'(req1_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_rsp($sformatf("t3_op%0d", k), 1'(k & 1),
                     (k & 1) ? 16'h0003 : 16'h0000,
                     (k & 1) ? 16'hFFFF : 16'hFFFC,
                     (k == 0) ? 3 : 4);
        end
        set_req(1'b0, 1'b0, 16'd16, 16'd0, 1'b1);
        set_req(1'b1, 1'b0, 16'd4,  16'd3, 1'b1);
        @(negedge clk);
        check("t3_end_busy", 32'(busy), 32'h0);

        // T4 backpressure with a pending request from the other requester
        rsp_ready = 1'b0;
        run_op("t4", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0007, 16'hFFF8);
        set_req(1'b0, 1'b1, 16'd4, 16'd3, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_hold_valid", 32'(rsp_valid),  32'h1);
            check("t4_hold_id",    32'(rsp_id),     32'h1);
            check("t4_hold_out1",  32'(rsp_out1),   32'h0007);
            check("t4_hold_out2",  32'(rsp_out2),   32'hFFF8);
            check("t4_hold_busy",  32'(busy),       32'h1);
            check("t4_hold_rdy0",  32'(req0_ready), 32'h0);
            check("t4_hold_rdy1",  32'(req1_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_rel_valid", 32'(rsp_valid),  32'h0);
        check("t4_rel_busy",  32'(busy),       32'h0);
        check("t4_rel_rdy0",  32'(req0_ready), 32'h1);
        @(negedge clk);
        set_req(1'b0, 1'b0, 16'd4, 16'd3, 1'b1);
        check("t4_pend_busy", 32'(busy), 32'h1);
        wait_rsp("t4_pend", 1'b0, 16'h0003, 16'hFFFF, 2);

        // T5 asynchronous reset while the op sits in T2
        @(negedge clk);
        set_req(1'b0, 1'b1, 16'd4, 16'd3, 1'b1);
        #1;
        check("t5_ready", 32'(req0_ready), 32'h1);
        @(posedge clk);
        #2;
        set_req(1'b0, 1'b0, 16'd4, 16'd3, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("t5_rst");
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("t5_no_rsp", 32'(seen), 32'h0);
        run_op("t5_next", 1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0007, 16'hFFF8);

`ifdef PROC_SCHED_STATS_EN
        // T6 grant counter saturation
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_cnt0_rst", 32'(grant0_cnt), 32'h0);
        check("t6_cnt1_rst", 32'(grant1_cnt), 32'h0);
        begin
            int got;
            int cyc;
            got = 0;
            cyc = 0;
            set_req(1'b0, 1'b1, 16'd16, 16'd0, 1'b1);
            while (got < 300 && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                if (rsp_valid) got++;
            end
            set_req(1'b0, 1'b0, 16'd16, 16'd0, 1'b1);
            check("t6_ops", 32'(got), 32'd300);
        end
        @(negedge clk);
        check("t6_cnt0", 32'(grant0_cnt), 32'd255);
        check("t6_cnt1", 32'(grant1_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
